// File: rtl/hack_loader_pkg.sv
// Shared types and protocol constants for the Hack ROM loader.
package hack_loader_pkg;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_CNT_HI  = 4'd1,
        S_CNT_LO  = 4'd2,
        S_DATA_HI = 4'd3,
        S_DATA_LO = 4'd4,
        S_WRITE   = 4'd5,
        S_VERIFY  = 4'd6,
        S_CHECK   = 4'd7,
        S_RESP    = 4'd8
    } state_t;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_HALT = 8'h48;
    localparam logic [7:0] RSP_ACK  = 8'h06;
    localparam logic [7:0] RSP_NAK  = 8'h15;

    // States in which the loader is waiting for an RX byte.
    function automatic logic rx_state(input state_t s);
        return (s == S_IDLE) || (s == S_CNT_HI) || (s == S_CNT_LO) ||
               (s == S_DATA_HI) || (s == S_DATA_LO) || (s == S_CHECK);
    endfunction

endpackage

// File: rtl/hack_loader_timeout.sv
// Inter-byte idle counter; expire rises once TIMEOUT_CYCLES uncleared cycles have elapsed.
module hack_loader_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic clear,
    output logic expire
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Saturating count so expire holds until the next clear.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_q != LIMIT) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_q <= '0;
            expire  <= 1'b0;
        end else begin
            count_q <= count_d;
            expire  <= (count_d == LIMIT);
        end
    end

endmodule

// File: rtl/hack_rom_loader.sv
// UART-fed ROM loader for the Hack system: parses L/R/H frames, writes ROM, controls CPU run.
// Define HACK_LOADER_VERIFY_EN to read back and compare every written word.
module hack_rom_loader
    import hack_loader_pkg::*;
#(
    parameter int unsigned ROM_DEPTH      = 1001,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_bus_ROM_cs,
    output logic [15:0] o_bus_ROM_addr,
    output logic        o_bus_ROM_write,
    output logic [15:0] o_bus_ROM_data,
    input  logic [15:0] i_bus_ROM_data,
    output logic        o_run,
    output logic        o_error
);

    state_t      state_q, state_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [7:0]  cksum_q, cksum_d;

    logic        rx_ready_d;
    logic [7:0]  tx_data_d;
    logic        tx_valid_d;
    logic        cs_d;
    logic [15:0] addr_d;
    logic        write_d;
    logic [15:0] wdata_d;
    logic        run_d;
    logic        error_d;

    logic        rx_xfer;
    logic        rx_wait;
    logic        in_frame;
    logic        tmo_clear;
    logic        expire;
    logic [7:0]  rx_sum;
    logic [15:0] rx_word;
    logic [15:0] addr_inc;
    logic        last_word;

    assign rx_xfer   = i_rx_valid && o_rx_ready;
    assign rx_wait   = rx_state(state_q) && (state_q != S_IDLE);
    assign in_frame  = (state_q != S_IDLE) && (state_q != S_RESP);
    assign tmo_clear = rx_xfer || !in_frame;
    assign rx_sum    = cksum_q + i_rx_data;
    assign rx_word   = {hi_q, i_rx_data};
    assign addr_inc  = o_bus_ROM_addr + 16'd1;
    assign last_word = (addr_inc == word_cnt_q);

`ifndef HACK_LOADER_VERIFY_EN
    logic unused_rom_rdata;
    assign unused_rom_rdata = ^i_bus_ROM_data;
`endif

    hack_loader_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .CLK   (CLK),
        .RST_N (RST_N),
        .clear (tmo_clear),
        .expire(expire)
    );

    // Frame parser: next state plus next value of every registered output.
    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        word_cnt_d = word_cnt_q;
        cksum_d    = cksum_q;
        tx_data_d  = o_tx_data;
        cs_d       = o_bus_ROM_cs;
        addr_d     = o_bus_ROM_addr;
        wdata_d    = o_bus_ROM_data;
        write_d    = 1'b0;
        run_d      = o_run;
        error_d    = o_error;

        case (state_q)
            S_IDLE: begin
                if (rx_xfer) begin
                    state_d   = S_RESP;
                    tx_data_d = RSP_ACK;
                    case (i_rx_data)
                        CMD_LOAD: begin
                            state_d = S_CNT_HI;
                            run_d   = 1'b0;
                            cs_d    = 1'b1;
                            error_d = 1'b0;
                            cksum_d = '0;
                            addr_d  = '0;
                        end
                        CMD_RUN: begin
                            cs_d  = 1'b0;
                            run_d = 1'b1;
                        end
                        CMD_HALT: begin
                            run_d = 1'b0;
                            cs_d  = 1'b1;
                        end
                        default: begin
                            tx_data_d = RSP_NAK;
                            error_d   = 1'b1;
                        end
                    endcase
                end
            end
            S_CNT_HI: begin
                if (rx_xfer) begin
                    hi_d    = i_rx_data;
                    cksum_d = rx_sum;
                    state_d = S_CNT_LO;
                end
            end
            S_CNT_LO: begin
                if (rx_xfer) begin
                    word_cnt_d = rx_word;
                    cksum_d    = rx_sum;
                    if (rx_word > 16'(ROM_DEPTH)) begin
                        state_d   = S_RESP;
                        tx_data_d = RSP_NAK;
                        error_d   = 1'b1;
                    end else if (rx_word == 16'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DATA_HI;
                    end
                end
            end
            S_DATA_HI: begin
                if (rx_xfer) begin
                    hi_d    = i_rx_data;
                    cksum_d = rx_sum;
                    state_d = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                if (rx_xfer) begin
                    cksum_d = rx_sum;
                    wdata_d = rx_word;
                    write_d = 1'b1;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
`ifdef HACK_LOADER_VERIFY_EN
                state_d = S_VERIFY;
`else
                addr_d  = addr_inc;
                state_d = last_word ? S_CHECK : S_DATA_HI;
`endif
            end
`ifdef HACK_LOADER_VERIFY_EN
            S_VERIFY: begin
                if (i_bus_ROM_data != o_bus_ROM_data) begin
                    state_d   = S_RESP;
                    tx_data_d = RSP_NAK;
                    error_d   = 1'b1;
                end else begin
                    addr_d  = addr_inc;
                    state_d = last_word ? S_CHECK : S_DATA_HI;
                end
            end
`endif
            S_CHECK: begin
                if (rx_xfer) begin
                    state_d = S_RESP;
                    if (i_rx_data == cksum_q) begin
                        tx_data_d = RSP_ACK;
                    end else begin
                        tx_data_d = RSP_NAK;
                        error_d   = 1'b1;
                    end
                end
            end
            S_RESP: begin
                if (i_tx_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A stalled sender aborts the frame.
        if (rx_wait && !rx_xfer && expire) begin
            state_d   = S_RESP;
            tx_data_d = RSP_NAK;
            error_d   = 1'b1;
        end

        tx_valid_d = (state_d == S_RESP);
        rx_ready_d = rx_state(state_d);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q         <= S_IDLE;
            hi_q            <= '0;
            word_cnt_q      <= '0;
            cksum_q         <= '0;
            o_rx_ready      <= 1'b0;
            o_tx_data       <= '0;
            o_tx_valid      <= 1'b0;
            o_bus_ROM_cs    <= 1'b1;
            o_bus_ROM_addr  <= '0;
            o_bus_ROM_write <= 1'b0;
            o_bus_ROM_data  <= '0;
            o_run           <= 1'b0;
            o_error         <= 1'b0;
        end else begin
            state_q         <= state_d;
            hi_q            <= hi_d;
            word_cnt_q      <= word_cnt_d;
            cksum_q         <= cksum_d;
            o_rx_ready      <= rx_ready_d;
            o_tx_data       <= tx_data_d;
            o_tx_valid      <= tx_valid_d;
            o_bus_ROM_cs    <= cs_d;
            o_bus_ROM_addr  <= addr_d;
            o_bus_ROM_write <= write_d;
            o_bus_ROM_data  <= wdata_d;
            o_run           <= run_d;
            o_error         <= error_d;
        end
    end

endmodule

// File: tb/tb_hack_rom_loader.sv
// Directed plus randomized bench for hack_rom_loader with a frame-level reference model.
module tb_hack_rom_loader;

    localparam int unsigned ROM_DEPTH = 1001;
    localparam int unsigned TMO       = 16;
    localparam logic [7:0]  ACK       = 8'h06;
    localparam logic [7:0]  NAK       = 8'h15;
`ifdef HACK_LOADER_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [7:0]  i_rx_data = 8'h00;
    logic        i_rx_valid = 1'b0;
    logic        o_rx_ready;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready = 1'b0;
    logic        o_bus_ROM_cs;
    logic [15:0] o_bus_ROM_addr;
    logic        o_bus_ROM_write;
    logic [15:0] o_bus_ROM_data;
    logic [15:0] i_bus_ROM_data;
    logic        o_run;
    logic        o_error;

    always #5 CLK = ~CLK;

    hack_rom_loader #(
        .ROM_DEPTH     (ROM_DEPTH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .i_rx_data      (i_rx_data),
        .i_rx_valid     (i_rx_valid),
        .o_rx_ready     (o_rx_ready),
        .o_tx_data      (o_tx_data),
        .o_tx_valid     (o_tx_valid),
        .i_tx_ready     (i_tx_ready),
        .o_bus_ROM_cs   (o_bus_ROM_cs),
        .o_bus_ROM_addr (o_bus_ROM_addr),
        .o_bus_ROM_write(o_bus_ROM_write),
        .o_bus_ROM_data (o_bus_ROM_data),
        .i_bus_ROM_data (i_bus_ROM_data),
        .o_run          (o_run),
        .o_error        (o_error)
    );

    // ROM model; corrupt_a1 forces a bad read-back at address 1.
    logic [15:0] rom [0:1023];
    logic        corrupt_a1 = 1'b0;
    assign i_bus_ROM_data = (corrupt_a1 && o_bus_ROM_addr == 16'd1) ? 16'h0000
                                                                  : rom[o_bus_ROM_addr[9:0]];

    int checks = 0;
    int failures = 0;
    logic [15:0] wr_addr_q[$];
    logic [15:0] wr_data_q[$];

    always @(posedge CLK) begin
        if (o_bus_ROM_write) begin
            checks++;
            assert (o_bus_ROM_cs === 1'b1) else begin
                failures++;
                $error("FAIL wr_cs observed=%b expected=1", o_bus_ROM_cs);
            end
            rom[o_bus_ROM_addr[9:0]] <= o_bus_ROM_data;
            wr_addr_q.push_back(o_bus_ROM_addr);
            wr_data_q.push_back(o_bus_ROM_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: whole-frame outcome from the protocol rules.
    logic [7:0]  frame[$];
    logic [15:0] exp_addr[$];
    logic [15:0] exp_data[$];
    logic [7:0]  exp_rsp;
    int          n_send;
    bit          err_known;
    int          bad_addr = -1;

    function automatic void model_load();
        int n;
        logic [7:0] sum;
        exp_addr.delete();
        exp_data.delete();
        n   = int'({frame[0], frame[1]});
        sum = frame[0] + frame[1];
        if (n > ROM_DEPTH) begin
            exp_rsp = NAK; n_send = 2; err_known = 1'b0;
            return;
        end
        for (int i = 0; i < n; i++) begin
            logic [15:0] w;
            w = {frame[2 + 2 * i], frame[3 + 2 * i]};
            exp_addr.push_back(16'(i));
            exp_data.push_back(w);
            sum = sum + frame[2 + 2 * i] + frame[3 + 2 * i];
            if (VERIFY && i == bad_addr && w != 16'h0000) begin
                exp_rsp = NAK; n_send = 4 + 2 * i; err_known = 1'b1;
                return;
            end
        end
        exp_rsp   = (frame[2 + 2 * n] == sum) ? ACK : NAK;
        n_send    = 3 + 2 * n;
        err_known = 1'b1;
    endfunction

    function automatic void build_frame(input int n, input bit good);
        logic [7:0] sum;
        logic [7:0] b;
        frame.delete();
        frame.push_back(8'(n >> 8));
        frame.push_back(8'(n));
        sum = frame[0] + frame[1];
        for (int i = 0; i < 2 * n; i++) begin
            b = 8'($urandom);
            frame.push_back(b);
            sum = sum + b;
        end
        frame.push_back(good ? sum : 8'(sum + 8'($urandom_range(1, 255))));
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        while (o_rx_ready !== 1'b1 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 50) chk("rx_ready_wait", 32'(o_rx_ready), 1);
        @(negedge CLK);
        i_rx_valid = 1'b0;
    endtask

    task automatic get_rsp(output logic [7:0] d, output int lat);
        int n = 0;
        int hold;
        while (o_tx_valid !== 1'b1 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        lat = n;
        chk("tx_valid_seen", 32'(o_tx_valid), 1);
        d = o_tx_data;
        hold = $urandom_range(0, 3);
        repeat (hold) begin
            @(negedge CLK);
            chk("tx_hold_valid", 32'(o_tx_valid), 1);
            chk("tx_hold_data", 32'(o_tx_data), 32'(d));
        end
        i_tx_ready = 1'b1;
        @(negedge CLK);
        i_tx_ready = 1'b0;
        chk("tx_valid_drop", 32'(o_tx_valid), 0);
    endtask

    task automatic run_load(input bit gaps);
        logic [7:0] rsp;
        int lat;
        int mism = 0;
        model_load();
        wr_addr_q.delete();
        wr_data_q.delete();
        send_byte(8'h4C);
        chk("load_run_off", 32'(o_run), 0);
        chk("load_cs_on", 32'(o_bus_ROM_cs), 1);
        chk("load_err_clr", 32'(o_error), 0);
        for (int k = 0; k < n_send; k++) begin
            if (gaps) repeat ($urandom_range(0, 3)) @(negedge CLK);
            send_byte(frame[k]);
        end
        get_rsp(rsp, lat);
        chk("load_rsp", 32'(rsp), 32'(exp_rsp));
        chk("wr_count", 32'(wr_addr_q.size()), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < wr_addr_q.size(); i++) begin
            if (wr_addr_q[i] !== exp_addr[i] || wr_data_q[i] !== exp_data[i]) mism++;
        end
        chk("wr_list", 32'(mism), 0);
        if (err_known) chk("load_err", 32'(o_error), 32'(exp_rsp == NAK));
    endtask

    task automatic cmd(input logic [7:0] c, input logic [7:0] exp);
        logic [7:0] rsp;
        int lat;
        send_byte(c);
        get_rsp(rsp, lat);
        chk("cmd_rsp", 32'(rsp), 32'(exp));
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0] rsp;
        int lat;

        // Reset values
        repeat (2) @(negedge CLK);
        chk("rst_cs", 32'(o_bus_ROM_cs), 1);
        chk("rst_run", 32'(o_run), 0);
        chk("rst_err", 32'(o_error), 0);
        chk("rst_txv", 32'(o_tx_valid), 0);
        chk("rst_wr", 32'(o_bus_ROM_write), 0);
        chk("rst_rdy", 32'(o_rx_ready), 0);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);
        chk("idle_rdy", 32'(o_rx_ready), 1);

        // Two-word load, good then bad checksum
        frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0};
        run_load(1'b0);
        chk("plan_ack", 32'(exp_rsp), 32'(ACK));
        frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC1};
        run_load(1'b0);
        frame = '{8'h00, 8'h01, 8'h55, 8'hAA, 8'h00};
        run_load(1'b1);

        // Oversized word count
        frame = '{8'h03, 8'hEA};
        run_load(1'b0);
        chk("oversize_idle_rdy", 32'(o_rx_ready), 1);

        // Run, then load while running
        chk("pre_run_cs", 32'(o_bus_ROM_cs), 1);
        chk("pre_run_run", 32'(o_run), 0);
        send_byte(8'h52);
        chk("run_cs", 32'(o_bus_ROM_cs), 0);
        chk("run_run", 32'(o_run), 1);
        get_rsp(rsp, lat);
        chk("run_rsp", 32'(rsp), 32'(ACK));
        frame = '{8'h00, 8'h00, 8'h00};
        run_load(1'b0);

        // Halt and illegal command
        cmd(8'h52, ACK);
        cmd(8'h48, ACK);
        chk("halt_run", 32'(o_run), 0);
        chk("halt_cs", 32'(o_bus_ROM_cs), 1);
        cmd(8'h5A, NAK);
        chk("bad_cmd_err", 32'(o_error), 1);

        // Stall after the first data byte
        wr_addr_q.delete();
        send_byte(8'h4C);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h12);
        get_rsp(rsp, lat);
        chk("tmo_rsp", 32'(rsp), 32'(NAK));
        chk("tmo_latency", 32'(lat >= 15 && lat <= 18), 1);
        chk("tmo_err", 32'(o_error), 1);
        chk("tmo_no_write", 32'(wr_addr_q.size()), 0);

        // Reset in mid-frame
        wr_addr_q.delete();
        send_byte(8'h4C);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hAB);
        RST_N = 1'b0;
        #1;
        chk("midrst_cs", 32'(o_bus_ROM_cs), 1);
        chk("midrst_rdy", 32'(o_rx_ready), 0);
        chk("midrst_wr", 32'(o_bus_ROM_write), 0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        repeat (4) @(negedge CLK);
        chk("midrst_no_write", 32'(wr_addr_q.size()), 0);

        // Randomized loads
        for (int it = 0; it < 10; it++) begin
            build_frame($urandom_range(0, 6), ($urandom_range(0, 1) == 1));
            run_load(1'b1);
        end

        // Full-depth load
        build_frame(ROM_DEPTH, 1'b1);
        run_load(1'b0);

`ifdef HACK_LOADER_VERIFY_EN
        // Read-back mismatch at address 1
        corrupt_a1 = 1'b1;
        bad_addr   = 1;
        frame = '{8'h00, 8'h03, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'hCC};
        run_load(1'b0);
        chk("verify_two_writes", 32'(wr_addr_q.size()), 2);
        corrupt_a1 = 1'b0;
        bad_addr   = -1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
